// File: rtl/alu_seq_pkg.sv
// Shared encodings for alu_seq: op codes, B-operand modes, FSM states and
// the nibble-count helper used to size the decimal iteration.
package alu_seq_pkg;

  localparam logic [2:0] OP_AI  = 3'd0;
  localparam logic [2:0] OP_ROL = 3'd1;
  localparam logic [2:0] OP_ROR = 3'd2;
  localparam logic [2:0] OP_ORA = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_EOR = 3'd5;
  localparam logic [2:0] OP_ADC = 3'd6;
  localparam logic [2:0] OP_BCD = 3'd7;

  localparam logic [1:0] BM_M     = 2'd0;
  localparam logic [1:0] BM_NOT_M = 2'd1;
  localparam logic [1:0] BM_CI    = 2'd2;
  localparam logic [1:0] BM_ZERO  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DEC  = 2'd2
  } state_t;

  function automatic int nibble_count(input int width);
    return width / 4;
  endfunction

endpackage

// File: rtl/alu_seq_bcd_digit.sv
// One-nibble decimal adder/subtractor; the subtract path expects b already
// inverted and carry acting as "no borrow".
module alu_seq_bcd_digit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  input  logic       sub,
  output logic [3:0] digit,
  output logic       carry
);

  logic [4:0] s;

  always_comb begin
    s = {1'b0, a} + {1'b0, b} + {4'b0000, c};
    if (sub) begin
      carry = s[4];
      digit = carry ? s[3:0] : s[3:0] + 4'd10;
    end else if (s > 5'd9) begin
      carry = 1'b1;
      digit = s[3:0] + 4'd6;
    end else begin
      carry = 1'b0;
      digit = s[3:0];
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Register file + ALU behind a start/busy/done handshake. With ALU_SEQ_BCD_EN
// defined, op 7 runs decimal add/subtract one nibble per cycle; otherwise op 7 is binary ADC.
//
// state  | meaning
// S_IDLE | waiting for start; done pulse (if any) shown here
// S_EXEC | single-cycle binary/logic op
// S_DEC  | nibble-serial decimal op, k = nibble in progress
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     RDY,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic                     a_mem,
  input  logic [$clog2(NREGS)-1:0] a_idx,
  input  logic [1:0]               b_mode,
  input  logic                     CI,
  input  logic                     ld,
  input  logic [$clog2(NREGS)-1:0] dst_idx,
  input  logic [WIDTH-1:0]         DB,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic                     CO,
  output logic                     N,
  output logic                     Z,
  output logic                     V
);

  localparam int IW = $clog2(NREGS);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] ai_q, ai_d, bi_q, bi_d;
  logic             ci_q, ci_d;
  logic [2:0]       op_q, op_d;
  logic             ld_q, ld_d;
  logic [IW-1:0]    dst_q, dst_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             co_q, co_d, n_q, n_d, z_q, z_d, v_q, v_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] ai_in, bi_in, alu_res, fin_res;
  logic [WIDTH:0]   sum_bin;
  logic             alu_co, alu_v, fin, fin_co, fin_v;

`ifdef ALU_SEQ_BCD_EN
  localparam int NIB = nibble_count(WIDTH);
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             sub_q, sub_d;
  logic [3:0]       digit;
  logic             dcarry;

  // Operands shift right each DEC cycle, so the digit adder always sees nibble 0.
  alu_seq_bcd_digit u_digit (
    .a    (ai_q[3:0]),
    .b    (bi_q[3:0]),
    .c    (ci_q),
    .sub  (sub_q),
    .digit(digit),
    .carry(dcarry)
  );
`endif

  always_comb begin
    ai_in = a_mem ? m_q : regs_q[a_idx];
    case (b_mode)
      BM_M:     bi_in = m_q;
      BM_NOT_M: bi_in = ~m_q;
      BM_CI:    bi_in = CI ? '0 : '1;
      default:  bi_in = '0;
    endcase
  end

  always_comb begin
    sum_bin = {1'b0, ai_q} + {1'b0, bi_q} + {{WIDTH{1'b0}}, ci_q};
    alu_res = '0;
    alu_co  = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_AI:  alu_res = ai_q;
      OP_ROL: begin
        alu_res = {ai_q[WIDTH-2:0], ci_q};
        alu_co  = ai_q[WIDTH-1];
      end
      OP_ROR: begin
        alu_res = {ci_q, ai_q[WIDTH-1:1]};
        alu_co  = ai_q[0];
      end
      OP_ORA: alu_res = ai_q | bi_q;
      OP_AND: alu_res = ai_q & bi_q;
      OP_EOR: alu_res = ai_q ^ bi_q;
      default: begin
        alu_res = sum_bin[WIDTH-1:0];
        alu_co  = sum_bin[WIDTH];
        alu_v   = (ai_q[WIDTH-1] ^ bi_q[WIDTH-1] ^ sum_bin[WIDTH-1]) ^ sum_bin[WIDTH];
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    regs_d   = regs_q;
    m_d      = DB;
    ai_d     = ai_q;
    bi_d     = bi_q;
    ci_d     = ci_q;
    op_d     = op_q;
    ld_d     = ld_q;
    dst_d    = dst_q;
    result_d = result_q;
    co_d     = co_q;
    n_d      = n_q;
    z_d      = z_q;
    v_d      = v_q;
    done_d   = 1'b0;
    fin      = 1'b0;
    fin_res  = alu_res;
    fin_co   = alu_co;
    fin_v    = alu_v;
`ifdef ALU_SEQ_BCD_EN
    k_d      = k_q;
    acc_d    = acc_q;
    sub_d    = sub_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          ai_d  = ai_in;
          bi_d  = bi_in;
          ci_d  = CI;
          op_d  = op;
          ld_d  = ld;
          dst_d = dst_idx;
`ifdef ALU_SEQ_BCD_EN
          sub_d = (b_mode == BM_NOT_M);
          if (op == OP_BCD) begin
            state_d = S_DEC;
            k_d     = '0;
            acc_d   = '0;
          end else begin
            state_d = S_EXEC;
          end
`else
          state_d = S_EXEC;
`endif
        end
      end
      S_EXEC: fin = 1'b1;
`ifdef ALU_SEQ_BCD_EN
      S_DEC: begin
        for (int i = 0; i < NIB; i++) begin
          if (k_q == KW'(i)) acc_d[i*4 +: 4] = digit;
        end
        ai_d = ai_q >> 4;
        bi_d = bi_q >> 4;
        ci_d = dcarry;
        k_d  = k_q + 1'b1;
        if (k_q == KW'(NIB - 1)) begin
          fin     = 1'b1;
          fin_res = acc_d;
          fin_co  = dcarry;
          // Upper bits of the shifted operands are zero here, so sum_bin[3]
          // is the binary top-nibble sum that NMOS parts derive V from.
          fin_v   = ~(ai_q[3] ^ bi_q[3]) & (ai_q[3] ^ sum_bin[3]);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      state_d  = S_IDLE;
      result_d = fin_res;
      co_d     = fin_co;
      n_d      = fin_res[WIDTH-1];
      z_d      = (fin_res == '0);
      v_d      = fin_v;
      done_d   = 1'b1;
      if (ld_q) regs_d[dst_q] = fin_res;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      regs_q   <= '{default: '0};
      m_q      <= '0;
      ai_q     <= '0;
      bi_q     <= '0;
      ci_q     <= 1'b0;
      op_q     <= OP_AI;
      ld_q     <= 1'b0;
      dst_q    <= '0;
      result_q <= '0;
      co_q     <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_SEQ_BCD_EN
      k_q      <= '0;
      acc_q    <= '0;
      sub_q    <= 1'b0;
`endif
    end else if (RDY) begin
      state_q  <= state_d;
      regs_q   <= regs_d;
      m_q      <= m_d;
      ai_q     <= ai_d;
      bi_q     <= bi_d;
      ci_q     <= ci_d;
      op_q     <= op_d;
      ld_q     <= ld_d;
      dst_q    <= dst_d;
      result_q <= result_d;
      co_q     <= co_d;
      n_q      <= n_d;
      z_q      <= z_d;
      v_q      <= v_d;
      done_q   <= done_d;
`ifdef ALU_SEQ_BCD_EN
      k_q      <= k_d;
      acc_q    <= acc_d;
      sub_q    <= sub_d;
`endif
    end
  end

  assign busy   = (state_q != S_IDLE) || done_q;
  assign done   = done_q;
  assign result = result_q;
  assign CO     = co_q;
  assign N      = n_q;
  assign Z      = z_q;
  assign V      = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq (8-bit instance plus a 16-bit instance);
// expectations follow ALU_SEQ_BCD_EN so either build can be checked.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic       clk, reset, RDY;
  logic       start, a_mem, CI, ld;
  logic [2:0] op;
  logic [1:0] a_idx, b_mode, dst_idx;
  logic [7:0] DB, result;
  logic       busy, done, CO, N, Z, V;

  logic        w_start, w_a_mem, w_ci, w_ld;
  logic [2:0]  w_op;
  logic [1:0]  w_a_idx, w_b_mode, w_dst;
  logic [15:0] w_db, w_result;
  logic        w_busy, w_done, w_co, w_n, w_z, w_v;

  int tests = 0;
  int fails = 0;

  alu_seq #(.WIDTH(8), .NREGS(4)) u_dut (
    .clk(clk), .reset(reset), .RDY(RDY), .start(start), .op(op), .a_mem(a_mem),
    .a_idx(a_idx), .b_mode(b_mode), .CI(CI), .ld(ld), .dst_idx(dst_idx), .DB(DB),
    .busy(busy), .done(done), .result(result), .CO(CO), .N(N), .Z(Z), .V(V)
  );

  alu_seq #(.WIDTH(16), .NREGS(4)) u_dut16 (
    .clk(clk), .reset(reset), .RDY(RDY), .start(w_start), .op(w_op), .a_mem(w_a_mem),
    .a_idx(w_a_idx), .b_mode(w_b_mode), .CI(w_ci), .ld(w_ld), .dst_idx(w_dst), .DB(w_db),
    .busy(w_busy), .done(w_done), .result(w_result), .CO(w_co), .N(w_n), .Z(w_z), .V(w_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic       a_mem;
    logic [1:0] a_idx;
    logic [1:0] b_mode;
    logic       ci;
    logic       ld;
    logic [1:0] dst;
    logic [7:0] r_init;
    logic [7:0] m;
    logic [7:0] exp_res;
    logic [3:0] exp_f;   // {CO,N,Z,V}
    int         exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input logic [2:0] o, input logic am,
                              input logic [1:0] ai, input logic [1:0] bm, input logic c,
                              input logic l, input logic [1:0] d, input logic [7:0] r,
                              input logic [7:0] m, input logic [7:0] er,
                              input logic [3:0] ef, input int el);
    vec_t v;
    v.name = nm; v.op = o; v.a_mem = am; v.a_idx = ai; v.b_mode = bm; v.ci = c;
    v.ld = l; v.dst = d; v.r_init = r; v.m = m; v.exp_res = er; v.exp_f = ef;
    v.exp_lat = el;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issues one op, scrambles the inputs after acceptance, and counts cycles to done.
  // stall > 0 drops RDY for that many cycles starting one cycle after acceptance.
  task automatic do_op(input logic [2:0] o, input logic am, input logic [1:0] ai,
                       input logic [1:0] bm, input logic c, input logic l,
                       input logic [1:0] d, input int stall, output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (busy && g < 20) begin
      @(negedge clk);
      g++;
    end
    start = 1'b1; op = o; a_mem = am; a_idx = ai; b_mode = bm; CI = c; ld = l; dst_idx = d;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~o; a_mem = ~am; a_idx = ~ai; b_mode = ~bm; CI = ~c; ld = 1'b0;
    dst_idx = ~d; DB = ~DB;
    lat = 0;
    do begin
      RDY = (lat >= 1 && lat < 1 + stall) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 50);
    RDY = 1'b1;
  endtask

  task automatic load_m(input logic [7:0] val);
    @(negedge clk);
    DB = val;
    @(posedge clk);
  endtask

  task automatic load_reg(input logic [1:0] idx, input logic [7:0] val);
    int lat;
    load_m(val);
    do_op(OP_AI, 1'b1, 2'd0, BM_ZERO, 1'b0, 1'b1, idx, 0, lat);
  endtask

  task automatic rd_reg(input logic [1:0] idx, output logic [7:0] val);
    int lat;
    do_op(OP_AI, 1'b0, idx, BM_ZERO, 1'b0, 1'b0, 2'd0, 0, lat);
    val = result;
  endtask

  task automatic do_op16(input logic [2:0] o, input logic am, input logic [1:0] bm,
                         input logic c, input logic l, output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (w_busy && g < 20) begin
      @(negedge clk);
      g++;
    end
    w_start = 1'b1; w_op = o; w_a_mem = am; w_a_idx = 2'd0; w_b_mode = bm; w_ci = c;
    w_ld = l; w_dst = 2'd0;
    @(posedge clk);
    #1;
    w_start = 1'b0; w_op = ~o; w_ci = ~c; w_ld = 1'b0; w_db = ~w_db;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!w_done && lat < 50);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int         lat, seen;
    logic [7:0] rv;
    vec_t       v;

    reset = 1'b1; RDY = 1'b1; start = 1'b0; op = '0; a_mem = 1'b0; a_idx = '0;
    b_mode = '0; CI = 1'b0; ld = 1'b0; dst_idx = '0; DB = '0;
    w_start = 1'b0; w_op = '0; w_a_mem = 1'b0; w_a_idx = '0; w_b_mode = '0; w_ci = 1'b0;
    w_ld = 1'b0; w_dst = '0; w_db = '0;

    vecs.push_back(mk("adc_ovf",  OP_ADC, 0, 2'd0, BM_M,     0, 1, 2'd0, 8'h50, 8'h50, 8'hA0, 4'b0101, 1));
    vecs.push_back(mk("adc_cmp",  OP_ADC, 0, 2'd1, BM_NOT_M, 1, 0, 2'd0, 8'h05, 8'h06, 8'hFF, 4'b0100, 1));
    vecs.push_back(mk("rol",      OP_ROL, 0, 2'd2, BM_ZERO,  1, 1, 2'd1, 8'h81, 8'h00, 8'h03, 4'b1000, 1));
    vecs.push_back(mk("ror",      OP_ROR, 0, 2'd0, BM_ZERO,  0, 0, 2'd0, 8'h01, 8'h00, 8'h00, 4'b1010, 1));
    vecs.push_back(mk("ora",      OP_ORA, 0, 2'd1, BM_M,     0, 0, 2'd0, 8'h0F, 8'hF0, 8'hFF, 4'b0100, 1));
    vecs.push_back(mk("and_z",    OP_AND, 0, 2'd2, BM_M,     0, 0, 2'd0, 8'hF0, 8'h0F, 8'h00, 4'b0010, 1));
    vecs.push_back(mk("eor_notm", OP_EOR, 0, 2'd3, BM_NOT_M, 0, 0, 2'd0, 8'hAA, 8'hFF, 8'hAA, 4'b0100, 1));
    vecs.push_back(mk("and_bmci", OP_AND, 0, 2'd0, BM_CI,    0, 0, 2'd0, 8'h3C, 8'h00, 8'h3C, 4'b0000, 1));
    vecs.push_back(mk("eor_bmci", OP_EOR, 0, 2'd1, BM_CI,    1, 0, 2'd0, 8'h3C, 8'hFF, 8'h3C, 4'b0000, 1));
    vecs.push_back(mk("ai_mem",   OP_AI,  1, 2'd0, BM_ZERO,  0, 1, 2'd3, 8'h00, 8'h80, 8'h80, 4'b0100, 1));
    vecs.push_back(mk("adc_wrap", OP_ADC, 0, 2'd2, BM_ZERO,  1, 0, 2'd0, 8'hFF, 8'h00, 8'h00, 4'b1010, 1));
    vecs.push_back(mk("adc_neg",  OP_ADC, 0, 2'd3, BM_M,     0, 0, 2'd0, 8'h80, 8'h80, 8'h00, 4'b1011, 1));
`ifdef ALU_SEQ_BCD_EN
    vecs.push_back(mk("bcd_add",  OP_BCD, 0, 2'd0, BM_M,     0, 1, 2'd0, 8'h58, 8'h46, 8'h04, 4'b1001, 2));
    vecs.push_back(mk("bcd_sub",  OP_BCD, 0, 2'd0, BM_NOT_M, 1, 1, 2'd0, 8'h12, 8'h21, 8'h91, 4'b0100, 2));
    vecs.push_back(mk("bcd_99",   OP_BCD, 0, 2'd1, BM_M,     0, 1, 2'd2, 8'h99, 8'h01, 8'h00, 4'b1010, 2));
`else
    vecs.push_back(mk("bcd_add",  OP_BCD, 0, 2'd0, BM_M,     0, 1, 2'd0, 8'h58, 8'h46, 8'h9E, 4'b0101, 1));
    vecs.push_back(mk("bcd_sub",  OP_BCD, 0, 2'd0, BM_NOT_M, 1, 1, 2'd0, 8'h12, 8'h21, 8'hF1, 4'b0100, 1));
    vecs.push_back(mk("bcd_99",   OP_BCD, 0, 2'd1, BM_M,     0, 1, 2'd2, 8'h99, 8'h01, 8'h9A, 4'b0100, 1));
`endif

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {CO, N, Z, V}, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      v = vecs[i];
      load_reg(v.a_idx, v.r_init);
      load_m(v.m);
      do_op(v.op, v.a_mem, v.a_idx, v.b_mode, v.ci, v.ld, v.dst, 0, lat);
      chk({v.name, "_lat"}, lat, v.exp_lat);
      chk({v.name, "_res"}, result, v.exp_res);
      chk({v.name, "_flags"}, {CO, N, Z, V}, v.exp_f);
      if (v.ld) begin
        rd_reg(v.dst, rv);
        chk({v.name, "_wb"}, rv, v.exp_res);
      end
    end

    // RDY held low for 3 cycles after the first nibble
    load_reg(2'd0, 8'h58);
    load_m(8'h46);
    do_op(OP_BCD, 1'b0, 2'd0, BM_M, 1'b0, 1'b1, 2'd0, 3, lat);
`ifdef ALU_SEQ_BCD_EN
    chk("stall_lat", lat, 5);
    chk("stall_res", result, 8'h04);
    chk("stall_co", CO, 1);
`else
    chk("stall_lat", lat, 1);
    chk("stall_res", result, 8'h9E);
    chk("stall_co", CO, 0);
`endif
    rd_reg(2'd0, rv);
`ifdef ALU_SEQ_BCD_EN
    chk("stall_wb", rv, 8'h04);
`else
    chk("stall_wb", rv, 8'h9E);
`endif

    // Same register as source and destination; done held through RDY low
    load_reg(2'd2, 8'h11);
    load_m(8'h22);
    do_op(OP_ADC, 1'b0, 2'd2, BM_M, 1'b0, 1'b1, 2'd2, 0, lat);
    chk("self_res", result, 8'h33);
    RDY = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("hold_done", done, 1);
    chk("hold_busy", busy, 1);
    RDY = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release", done, 0);
    load_m(8'h22);
    do_op(OP_ADC, 1'b0, 2'd2, BM_M, 1'b0, 1'b1, 2'd2, 0, lat);
    rd_reg(2'd2, rv);
    chk("self_wb", rv, 8'h55);

    // 16-bit instance: 0x9999 + 0x0001
    @(negedge clk);
    w_db = 16'h9999;
    @(posedge clk);
    do_op16(OP_AI, 1'b1, BM_ZERO, 1'b0, 1'b1, lat);
    @(negedge clk);
    w_db = 16'h0001;
    @(posedge clk);
    do_op16(OP_BCD, 1'b0, BM_M, 1'b0, 1'b1, lat);
`ifdef ALU_SEQ_BCD_EN
    chk("w16_lat", lat, 4);
    chk("w16_res", w_result, 16'h0000);
    chk("w16_flags", {w_co, w_n, w_z, w_v}, 4'b1010);
`else
    chk("w16_lat", lat, 1);
    chk("w16_res", w_result, 16'h999A);
    chk("w16_flags", {w_co, w_n, w_z, w_v}, 4'b0100);
`endif

    // Reset while an op is in flight
    load_reg(2'd0, 8'h58);
    load_reg(2'd1, 8'h80);
    load_m(8'h46);
    @(negedge clk);
    start = 1'b1; op = OP_BCD; a_mem = 1'b0; a_idx = 2'd0; b_mode = BM_M; CI = 1'b0;
    ld = 1'b1; dst_idx = 2'd0;
    @(posedge clk);
    #1;
    start = 1'b0; ld = 1'b0;
    chk("pre_rst_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_flags", {CO, N, Z, V}, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    chk("mid_rst_no_done", seen, 0);
    rd_reg(2'd0, rv);
    chk("mid_rst_r0", rv, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
